// File: rtl/debounce_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl
// Purpose  : N-channel switch debouncer. One free-running prescaler tick is
//            shared by per-channel IDLE/CONFIRM FSMs. Confirmed level changes
//            queue as pending events that a round-robin arbiter drains onto
//            a single valid/ready event port.
// Revision : 1.0 - initial release
// ============================================================================

module debounce_scan_ctrl #(
  parameter int N = 4,
  parameter int M = 1_000_000,
  parameter int K = 3,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N-1:0]    sw_i,
  output logic [N-1:0]    db_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [ID_W-1:0] evt_id_o,
  output logic            evt_level_o,
  output logic            evt_overflow_o,
  input  logic            clr_overflow_i
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(K + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(M - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(K - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONFIRM = 1'b1
  } ch_state_e;

  logic [N-1:0]    sync1_q;
  logic [N-1:0]    sync2_q;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic            tick;

  ch_state_e       state_q [N];
  ch_state_e       state_d [N];
  logic [CW-1:0]   cnt_q   [N];
  logic [CW-1:0]   cnt_d   [N];
  logic [N-1:0]    db_q;
  logic [N-1:0]    db_d;
  logic [N-1:0]    ch_evt;

  logic [N-1:0]    pend_q;
  logic [N-1:0]    pend_d;
  logic [N-1:0]    pend_lvl_q;
  logic [N-1:0]    pend_lvl_d;

  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] rr_d;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            load;
  logic            ovf_set;

  logic            evt_valid_q;
  logic            evt_valid_d;
  logic [ID_W-1:0] evt_id_q;
  logic [ID_W-1:0] evt_id_d;
  logic            evt_level_q;
  logic            evt_level_d;
  logic            evt_ovf_q;
  logic            evt_ovf_d;

  // Two-flop synchronizer bringing the raw switch levels into the clk domain
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Shared mod-M timebase; tick is high during the last count of each period
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register, free running
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-channel confirm FSMs: a new level must survive K shared ticks
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      db_d[i]    = db_q[i];
      ch_evt[i]  = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (sync2_q[i] != db_q[i]) begin
            state_d[i] = ST_CONFIRM;
            cnt_d[i]   = '0;
          end
        end
        ST_CONFIRM: begin
          if (sync2_q[i] == db_q[i]) begin
            // Bounced back before confirmation: discard the window
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              db_d[i]    = ~db_q[i];
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
              ch_evt[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Channel FSM state, confirm counters and debounced levels
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      db_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // Round-robin search: first pending channel at or after the rr pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < N; off++) begin
      cand = ID_W'((int'(rr_q) + off) % N);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load = (!evt_valid_q || evt_ready_i) && grant_found;

  // Pending bookkeeping, overflow detection and output register next state
  always_comb begin
    pend_d      = pend_q;
    pend_lvl_d  = pend_lvl_q;
    ovf_set     = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_level_d = evt_level_q;
    rr_d        = rr_q;

    for (int i = 0; i < N; i++) begin
      if (load && (grant_idx == ID_W'(i))) begin
        pend_d[i] = 1'b0;
      end
      // A new confirmation wins over a same-cycle grant; it only counts as
      // an overflow when the older event is not leaving this cycle.
      if (ch_evt[i]) begin
        if (pend_q[i] && !(load && (grant_idx == ID_W'(i)))) begin
          ovf_set = 1'b1;
        end
        pend_d[i]     = 1'b1;
        pend_lvl_d[i] = db_d[i];
      end
    end

    if (load) begin
      evt_valid_d = 1'b1;
      evt_id_d    = grant_idx;
      evt_level_d = pend_lvl_q[grant_idx];
      rr_d        = ID_W'((int'(grant_idx) + 1) % N);
    end else if (evt_ready_i) begin
      evt_valid_d = 1'b0;
    end

    if (ovf_set) begin
      evt_ovf_d = 1'b1;
    end else if (clr_overflow_i) begin
      evt_ovf_d = 1'b0;
    end else begin
      evt_ovf_d = evt_ovf_q;
    end
  end

  // Pending flags, arbiter pointer and event output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q      <= '0;
      pend_lvl_q  <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_level_q <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_lvl_q  <= pend_lvl_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_level_q <= evt_level_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign db_o           = db_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_id_o       = evt_id_q;
  assign evt_level_o    = evt_level_q;
  assign evt_overflow_o = evt_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scan_ctrl
// Purpose  : Directed self-checking bench for debounce_scan_ctrl with N=4,
//            M=4, K=3 and an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_debounce_scan_ctrl;

  localparam int N = 4;
  localparam int M = 4;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = '0;
  logic [3:0] db;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_id;
  logic       evt_level;
  logic       evt_overflow;
  logic       clr_overflow = 1'b0;

  typedef struct packed {
    logic [1:0] id;
    logic       lvl;
  } evt_t;

  evt_t       sb_q [$];
  evt_t       exp_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         c = 0;          // edges since reset release
  logic [3:0] m_db = '0;      // expected debounced levels

  debounce_scan_ctrl #(.N(N), .M(M), .K(K)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .sw_i           (sw),
    .db_o           (db),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (evt_ready),
    .evt_id_o       (evt_id),
    .evt_level_o    (evt_level),
    .evt_overflow_o (evt_overflow),
    .clr_overflow_i (clr_overflow)
  );

  always #5 clk = ~clk;

  // Edge c consumes a tick when c % M == 0. A change driven after edge c0 is
  // synchronized by c0+2 and enters CONFIRM on c0+3, so the first tick that
  // counts is at or after c0+4; db toggles K-1 periods later.
  function automatic int db_edge(input int c0);
    int t;
    t = c0 + 4;
    while ((t % M) != 0) t++;
    return t + (K - 1) * M;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    c++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    c = 0;
    m_db = '0;
  endtask

  // Drive new levels on the masked channels and step to the predicted edge,
  // checking db just before and just after it.
  task automatic settle(input logic [3:0] mask, input logic [3:0] val,
                        input bit clr_last, input string tag);
    int e;
    sw = (sw & ~mask) | (val & mask);
    e = db_edge(c);
    while (c < e - 1) step();
    check({tag, " db before"}, 32'(db), 32'(m_db));
    if (clr_last) clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    m_db = (m_db & ~mask) | (val & mask);
    check({tag, " db after"}, 32'(db), 32'(m_db));
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL evt unexpected: observed id %0d level %0b expected none", evt_id, evt_level);
      end
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        n_cmp++;
        assert ({evt_id, evt_level} === {exp_e.id, exp_e.lvl}) else begin
          n_err++;
          $error("FAIL evt payload: observed id %0d level %0b expected id %0d level %0b",
                 evt_id, evt_level, exp_e.id, exp_e.lvl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step();
    do_reset();
    check("rst db", 32'(db), 32'h0);
    check("rst valid", 32'(evt_valid), 32'h0);
    check("rst id", 32'(evt_id), 32'h0);
    check("rst level", 32'(evt_level), 32'h0);
    check("rst ovf", 32'(evt_overflow), 32'h0);

    // Single press on channel 0, consumer always ready
    evt_ready = 1'b1;
    step();
    settle(4'b0001, 4'b0001, 1'b0, "t1 rise");
    sb_q.push_back('{id: 2'd0, lvl: 1'b1});
    check("t1 valid at db edge", 32'(evt_valid), 32'h0);
    step();
    check("t1 valid next", 32'(evt_valid), 32'h1);
    step();
    check("t1 valid one cycle", 32'(evt_valid), 32'h0);
    settle(4'b0001, 4'b0000, 1'b0, "t1 fall");
    sb_q.push_back('{id: 2'd0, lvl: 1'b0});
    step();
    step();
    check("t1 sb empty", 32'(sb_q.size()), 32'h0);

    // Glitch on channel 1 shorter than the confirm window
    sw[1] = 1'b1;
    repeat (6) step();
    sw[1] = 1'b0;
    repeat (20) step();
    check("t2 glitch db", 32'(db), 32'(m_db));
    check("t2 no valid", 32'(evt_valid), 32'h0);

    // Simultaneous completions on 0, 2, 3 drained round robin
    do_reset();
    evt_ready = 1'b0;
    settle(4'b1101, 4'b1101, 1'b0, "t3 rise");
    check("t3 valid at db edge", 32'(evt_valid), 32'h0);
    step();
    check("t3 head valid", 32'(evt_valid), 32'h1);
    check("t3 head id", 32'(evt_id), 32'h0);
    repeat (3) step();
    check("t3 stall valid", 32'(evt_valid), 32'h1);
    check("t3 stall id", 32'(evt_id), 32'h0);
    sb_q.push_back('{id: 2'd0, lvl: 1'b1});
    sb_q.push_back('{id: 2'd2, lvl: 1'b1});
    sb_q.push_back('{id: 2'd3, lvl: 1'b1});
    evt_ready = 1'b1;
    repeat (3) step();
    check("t3 drained valid", 32'(evt_valid), 32'h0);
    check("t3 sb empty", 32'(sb_q.size()), 32'h0);

    // Overflow on channel 1 while channel 0's release is stalled
    evt_ready = 1'b0;
    settle(4'b0001, 4'b0000, 1'b0, "t4 ch0 fall");
    sb_q.push_back('{id: 2'd0, lvl: 1'b0});
    step();
    check("t4 stalled id", 32'(evt_id), 32'h0);
    check("t4 stalled level", 32'(evt_level), 32'h0);
    settle(4'b0010, 4'b0010, 1'b0, "t4 ch1 rise");
    check("t4 no ovf yet", 32'(evt_overflow), 32'h0);
    settle(4'b0010, 4'b0000, 1'b0, "t4 ch1 fall");
    check("t4 ovf set", 32'(evt_overflow), 32'h1);
    sb_q.push_back('{id: 2'd1, lvl: 1'b0});
    evt_ready = 1'b1;
    step();
    step();
    check("t4 drained valid", 32'(evt_valid), 32'h0);
    check("t4 sb empty", 32'(sb_q.size()), 32'h0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t4 ovf cleared", 32'(evt_overflow), 32'h0);

    // New overflow in the same cycle as clr_overflow: set wins
    evt_ready = 1'b0;
    settle(4'b0100, 4'b0000, 1'b0, "t4 ch2 fall");
    sb_q.push_back('{id: 2'd2, lvl: 1'b0});
    step();
    settle(4'b0100, 4'b0100, 1'b0, "t4 ch2 rise");
    settle(4'b0100, 4'b0000, 1'b1, "t4 ch2 fall again");
    check("t4 set beats clear", 32'(evt_overflow), 32'h1);
    sb_q.push_back('{id: 2'd2, lvl: 1'b0});
    evt_ready = 1'b1;
    step();
    step();
    check("t4b drained valid", 32'(evt_valid), 32'h0);
    check("t4b sb empty", 32'(sb_q.size()), 32'h0);

    // Reset with an event stalled, one pending and channel 2 mid-confirm
    evt_ready = 1'b0;
    settle(4'b1010, 4'b0010, 1'b0, "t5 ch1 up ch3 down");
    step();
    check("t5 stalled id", 32'(evt_id), 32'h3);
    check("t5 ovf before reset", 32'(evt_overflow), 32'h1);
    sw[2] = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("t5 reset valid", 32'(evt_valid), 32'h0);
    check("t5 reset db", 32'(db), 32'h0);
    check("t5 reset ovf", 32'(evt_overflow), 32'h0);
    check("t5 reset id", 32'(evt_id), 32'h0);
    reset = 1'b0;
    c = 0;
    m_db = '0;
    evt_ready = 1'b1;
    // sw[1] and sw[2] are still high: a complete window from reset release
    settle(4'b0110, 4'b0110, 1'b0, "t5 after reset");
    sb_q.push_back('{id: 2'd1, lvl: 1'b1});
    sb_q.push_back('{id: 2'd2, lvl: 1'b1});
    repeat (3) step();
    check("t5 drained valid", 32'(evt_valid), 32'h0);
    check("t5 sb empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
